fp_mac_pipe: RTL and testbench
==============================

Name: fp_mac_pipe

Overview:
Parametrised, pipelined floating-point multiply-accumulate unit. It computes acc = sum(a*b) over a stream of operand pairs and supports a per-sample accumulator restart. Formats are IEEE-754-like, with configurable exponent and mantissa widths. It is the streaming successor to the single-precision MAC: it adds a valid handshake, accumulate/restart mode, a term counter and sticky overflow, and sits between the operand-conversion front end and the result consumer.

Parameters:
EXP_W, 8, exponent field width; BIAS = 2^(EXP_W-1)-1.
MAN_W, 23, stored mantissa width; the hidden 1 is implicit.
CNT_W, 16, width of the accumulated-term counter.

Ports:
clk  input  1  rising-edge clock.
rst  input  1  asynchronous, active-high reset.
in_valid  input  1  a and b valid this cycle.
a  input  1+EXP_W+MAN_W  multiplicand, {sign, exp, man}.
b  input  1+EXP_W+MAN_W  multiplier, same format.
acc_clr  input  1  restart the accumulation with this sample; sampled every cycle.
out_valid  output  1  one-cycle pulse: acc updated by a sample.
acc  output  1+EXP_W+MAN_W  running sum.
count  output  CNT_W  number of products summed since the last clear.
ovf  output  1  sticky overflow flag.

Behaviour:
- Reset (async, rst=1): acc=0, count=0, ovf=0, out_valid=0, all pipeline valid/clr flags=0. In-flight samples are discarded.
- No backpressure. A new sample can be accepted every cycle. Latency is 2: a sample accepted at edge N updates acc, count and out_valid at edge N+2.
- Stage 1 (product register), on a clock edge with in_valid=1:
  - sign = sa^sb.
  - exp = ea+eb-BIAS.
  - mantissa = (1.ma)*(1.mb), 2*(MAN_W+1) bits. If the MSB is set, shift right 1 and increment exp.
  - Truncate to MAN_W bits (round toward zero).
  - Either operand with exp=0 (zero or denormal) gives product = +0. Denormals are flushed.
  - Biased exp <= 0 gives +0 (underflow flush).
  - Biased exp >= 2^EXP_W-1, or either operand exp all-ones, gives an infinity product {sign, all-ones, 0} with the prod_ovf tag set.
  - NaN inputs are unsupported and treated as infinity.
  - acc_clr is registered alongside the product.
- Stage 2 (accumulate), when the stage-1 valid is set:
  - clr=1: acc <= product, count <= 1, ovf <= prod_ovf.
  - clr=0 and ovf=0: acc <= acc + product, count <= count+1 (saturating at 2^CNT_W-1).
  - Add rules: align the smaller-exponent operand by right shift, truncating shifted-out bits. Add or subtract the magnitudes; the result takes the sign of the larger magnitude. Renormalise with a leading-zero shift left or a single right shift.
  - Exact cancellation gives +0. Result exp <= 0 gives +0. Result exp >= 2^EXP_W-1 gives {sign, all-ones, 0} and sets ovf.
  - If ovf=1 and clr=0: acc holds (saturated), count still increments, out_valid still pulses.
  - out_valid=1 for exactly one cycle per accepted sample.
- acc_clr with in_valid=0 restarts without a sample: two cycles later acc=+0, count=0, ovf=0, and out_valid stays 0.
- Simultaneous in_valid and acc_clr: the sample starts the new sum (clr=1 path). It is not added to the old sum.
- Back-to-back samples: each stage-2 add uses acc as updated by the previous sample. There is no hazard, because the accumulate step is single-cycle.
- Outputs hold their values between samples.

Test Plan:
1. Reset, then a=0x3FC00000 (1.5), b=0x40000000 (2.0), in_valid=1, acc_clr=1 for one cycle -> two edges later out_valid=1 for one cycle, acc=0x40400000 (3.0), count=1, ovf=0.
2. Continue from 1 with a=b=0x3F800000 (1.0), acc_clr=0 -> acc=0x40800000 (4.0), count=2. Then a=0xC0000000, b=0x40000000 (-4.0) -> acc=0x00000000, count=3.
3. Three consecutive cycles of a=b=0x3F800000, with acc_clr=1 on the first only -> out_valid high for 3 consecutive cycles, acc=0x3F800000, 0x40000000, 0x40400000, count=1, 2, 3.
4. a=b=0x7F000000, acc_clr=1 -> acc=0x7F800000, ovf=1. A following 1.0*1.0 -> acc stays 0x7F800000, count=2. Then acc_clr alone -> acc=0, count=0, ovf=0, out_valid=0.
5. a=0x00400000 (denormal), b=0x40000000, acc_clr=1 -> acc=0x00000000. Also a=0x20000000, b=0x1F000000 (underflow) -> acc unchanged at +0, count=2.
6. Issue a sample, assert rst one cycle later (mid-flight) -> all outputs 0 immediately. After release, no out_valid pulse from the discarded sample.

Source files
------------

// File: rtl/fp_mac_pipe.sv
// fp_mac_pipe: two-stage streaming floating-point multiply-accumulate.
// Stage 1 registers the truncated product, stage 2 folds it into the running sum.
// Denormals are flushed, rounding is toward zero, overflow saturates to infinity.
module fp_mac_pipe #(
   parameter int EXP_W = 8,
   parameter int MAN_W = 23,
   parameter int CNT_W = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   input  logic [EXP_W+MAN_W:0]   a,
   input  logic [EXP_W+MAN_W:0]   b,
   input  logic                   acc_clr,
   output logic                   out_valid,
   output logic [EXP_W+MAN_W:0]   acc,
   output logic [CNT_W-1:0]       count,
   output logic                   ovf
);

   localparam int W    = 1 + EXP_W + MAN_W;
   localparam int PW   = 2 * (MAN_W + 1);
   localparam int XW   = EXP_W + 2;
   localparam int BIAS = 2**(EXP_W-1) - 1;
   localparam int LZ_W = $clog2(MAN_W + 2);
   localparam logic [XW-1:0] BIAS_X = XW'(BIAS);
   localparam logic [XW-1:0] EMAX_X = XW'(2**EXP_W - 1);

   // Leading-zero count of a (MAN_W+1)-bit mantissa; the highest set bit wins.
   function automatic logic [LZ_W-1:0] f_lzc(input logic [MAN_W:0] v);
      logic [LZ_W-1:0] n;
      n = '0;
      for (int i = 0; i <= MAN_W; i++) begin
         if (v[i]) n = LZ_W'(MAN_W - i);
      end
      return n;
   endfunction

   // ---------------- stage 1: multiply ----------------
   logic               w_sa, w_sb;
   logic [EXP_W-1:0]   w_ea, w_eb;
   logic [MAN_W-1:0]   w_ma, w_mb;
   logic [PW-1:0]      w_mprod;
   logic               w_p_msb;
   logic [MAN_W-1:0]   w_p_man;
   logic [XW-1:0]      w_p_exp;
   logic [W-1:0]       w_prod;
   logic               w_prod_ovf;

   assign w_sa    = a[W-1];
   assign w_sb    = b[W-1];
   assign w_ea    = a[W-2 -: EXP_W];
   assign w_eb    = b[W-2 -: EXP_W];
   assign w_ma    = a[MAN_W-1:0];
   assign w_mb    = b[MAN_W-1:0];
   assign w_mprod = {{(MAN_W+1){1'b0}}, 1'b1, w_ma} * {{(MAN_W+1){1'b0}}, 1'b1, w_mb};
   assign w_p_msb = w_mprod[PW-1];
   assign w_p_man = w_p_msb ? w_mprod[PW-2 -: MAN_W] : w_mprod[PW-3 -: MAN_W];
   // Two extra bits: bit XW-1 acts as the sign of the unbiased-minus-bias result.
   assign w_p_exp = XW'(w_ea) + XW'(w_eb) - BIAS_X + XW'(w_p_msb);

   // Classify the product: zero operands win, then infinities, then range checks.
   always_comb begin
      w_prod     = '0;
      w_prod_ovf = 1'b0;
      if ((w_ea == '0) || (w_eb == '0)) begin
         w_prod = '0;
      end else if ((&w_ea) || (&w_eb) || (!w_p_exp[XW-1] && (w_p_exp >= EMAX_X))) begin
         w_prod     = {w_sa ^ w_sb, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
         w_prod_ovf = 1'b1;
      end else if (w_p_exp[XW-1] || (w_p_exp == '0)) begin
         w_prod = '0;
      end else begin
         w_prod = {w_sa ^ w_sb, w_p_exp[EXP_W-1:0], w_p_man};
      end
   end

   logic               r_s1_valid;
   logic               r_s1_clr;
   logic [W-1:0]       r_prod;
   logic               r_prod_ovf;

   // Product register; the clear flag travels with every cycle, sample or not.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_s1_valid <= 1'b0;
         r_s1_clr   <= 1'b0;
         r_prod     <= '0;
         r_prod_ovf <= 1'b0;
      end else begin
         r_s1_valid <= in_valid;
         r_s1_clr   <= acc_clr;
         if (in_valid) begin
            r_prod     <= w_prod;
            r_prod_ovf <= w_prod_ovf;
         end
      end
   end

   // ---------------- stage 2: accumulate ----------------
   logic               w_as, w_ps;
   logic [EXP_W-1:0]   w_ae, w_pe;
   logic [MAN_W-1:0]   w_am, w_pm;
   logic               w_prod_big;
   logic               w_big_s;
   logic [EXP_W-1:0]   w_big_e, w_sml_e, w_ediff;
   logic [MAN_W:0]     w_big_f, w_sml_f, w_sml_sh;
   logic [MAN_W+1:0]   w_sum;
   logic [LZ_W-1:0]    w_lz;
   logic [MAN_W:0]     w_norm;
   logic [XW-1:0]      w_res_exp;
   logic [MAN_W-1:0]   w_res_man;
   logic [W-1:0]       w_add_res;
   logic               w_add_ovf;
   logic [CNT_W-1:0]   w_cnt_inc;

   assign w_as = acc[W-1];
   assign w_ae = acc[W-2 -: EXP_W];
   assign w_am = acc[MAN_W-1:0];
   assign w_ps = r_prod[W-1];
   assign w_pe = r_prod[W-2 -: EXP_W];
   assign w_pm = r_prod[MAN_W-1:0];

   // A zero exponent means a zero value, so its hidden bit is clear.
   assign w_prod_big = {w_pe, w_pm} > {w_ae, w_am};
   assign w_big_s    = w_prod_big ? w_ps : w_as;
   assign w_big_e    = w_prod_big ? w_pe : w_ae;
   assign w_sml_e    = w_prod_big ? w_ae : w_pe;
   assign w_big_f    = w_prod_big ? {(|w_pe), w_pm} : {(|w_ae), w_am};
   assign w_sml_f    = w_prod_big ? {(|w_ae), w_am} : {(|w_pe), w_pm};
   assign w_ediff    = w_big_e - w_sml_e;
   assign w_sml_sh   = w_sml_f >> w_ediff;
   assign w_sum      = (w_ps == w_as) ? ({1'b0, w_big_f} + {1'b0, w_sml_sh})
                                      : ({1'b0, w_big_f} - {1'b0, w_sml_sh});
   assign w_lz       = f_lzc(w_sum[MAN_W:0]);
   assign w_cnt_inc  = (&count) ? count : count + CNT_W'(1);

   // Renormalise the raw sum and apply the zero / overflow limits.
   always_comb begin
      w_add_res = '0;
      w_add_ovf = 1'b0;
      w_norm    = '0;
      w_res_exp = '0;
      w_res_man = '0;
      if (r_prod_ovf) begin
         w_add_res = {w_ps, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
         w_add_ovf = 1'b1;
      end else if (w_sum != '0) begin
         if (w_sum[MAN_W+1]) begin
            w_res_exp = XW'(w_big_e) + XW'(1);
            w_res_man = w_sum[MAN_W:1];
         end else begin
            w_res_exp = XW'(w_big_e) - XW'(w_lz);
            w_norm    = w_sum[MAN_W:0] << w_lz;
            w_res_man = w_norm[MAN_W-1:0];
         end
         if (!w_res_exp[XW-1] && (w_res_exp >= EMAX_X)) begin
            w_add_res = {w_big_s, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            w_add_ovf = 1'b1;
         end else if (w_res_exp[XW-1] || (w_res_exp == '0)) begin
            w_add_res = '0;
         end else begin
            w_add_res = {w_big_s, w_res_exp[EXP_W-1:0], w_res_man};
         end
      end
   end

   // Accumulator: restart, add, or hold once saturated; count always tracks samples.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid <= 1'b0;
         acc       <= '0;
         count     <= '0;
         ovf       <= 1'b0;
      end else begin
         out_valid <= r_s1_valid;
         if (r_s1_valid) begin
            if (r_s1_clr) begin
               acc   <= r_prod;
               count <= CNT_W'(1);
               ovf   <= r_prod_ovf;
            end else if (!ovf) begin
               acc   <= w_add_res;
               count <= w_cnt_inc;
               ovf   <= w_add_ovf;
            end else begin
               count <= w_cnt_inc;
            end
         end else if (r_s1_clr) begin
            acc   <= '0;
            count <= '0;
            ovf   <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_fp_mac_pipe.sv
// Directed bench for fp_mac_pipe with single-precision operands.
module tb_fp_mac_pipe;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic [31:0] a_i, b_i;
   logic        acc_clr;
   logic        out_valid;
   logic [31:0] acc;
   logic [15:0] count;
   logic        ovf;

   int errors = 0;
   int checks = 0;

   fp_mac_pipe #(.EXP_W(8), .MAN_W(23), .CNT_W(16)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .a         (a_i),
      .b         (b_i),
      .acc_clr   (acc_clr),
      .out_valid (out_valid),
      .acc       (acc),
      .count     (count),
      .ovf       (ovf)
   );

   always #5 clk = ~clk;

   // Drive one cycle of inputs just after the next rising edge.
   task automatic send(input logic v, input logic [31:0] av, input logic [31:0] bv,
                       input logic clr);
      @(posedge clk);
      #1;
      in_valid = v;
      a_i      = av;
      b_i      = bv;
      acc_clr  = clr;
   endtask

   task automatic idle();
      send(1'b0, 32'h0, 32'h0, 1'b0);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b0; a_i = '0; b_i = '0; acc_clr = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if ({out_valid, acc, count, ovf} !== 50'h0) begin
         errors++;
         $display("FAIL reset_state: ov=%0b acc=%h cnt=%0d ovf=%0b, want all zero",
                  out_valid, acc, count, ovf);
      end
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_basic();
      send(1'b1, 32'h3FC00000, 32'h40000000, 1'b1);
      idle();
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("FAIL early_valid: out_valid=%0b after one edge, want 0", out_valid);
      end
      step();
      checks++;
      if (out_valid !== 1'b1 || acc !== 32'h40400000 || count !== 16'd1 || ovf !== 1'b0) begin
         errors++;
         $display("FAIL mul_1p5x2: ov=%0b acc=%h cnt=%0d ovf=%0b, want 1 40400000 1 0",
                  out_valid, acc, count, ovf);
      end
      step();
      checks++;
      if (out_valid !== 1'b0 || acc !== 32'h40400000) begin
         errors++;
         $display("FAIL pulse_hold: ov=%0b acc=%h, want 0 40400000", out_valid, acc);
      end
   endtask

   task automatic test_accumulate();
      send(1'b1, 32'h3F800000, 32'h3F800000, 1'b0);
      idle();
      step();
      checks++;
      if (acc !== 32'h40800000 || count !== 16'd2 || out_valid !== 1'b1) begin
         errors++;
         $display("FAIL acc_3plus1: acc=%h cnt=%0d ov=%0b, want 40800000 2 1", acc, count, out_valid);
      end
      send(1'b1, 32'hC0000000, 32'h40000000, 1'b0);
      idle();
      step();
      checks++;
      if (acc !== 32'h00000000 || count !== 16'd3) begin
         errors++;
         $display("FAIL cancel_zero: acc=%h cnt=%0d, want 00000000 3", acc, count);
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] exp_acc [3];
      exp_acc[0] = 32'h3F800000;
      exp_acc[1] = 32'h40000000;
      exp_acc[2] = 32'h40400000;
      send(1'b1, 32'h3F800000, 32'h3F800000, 1'b1);
      send(1'b1, 32'h3F800000, 32'h3F800000, 1'b0);
      send(1'b1, 32'h3F800000, 32'h3F800000, 1'b0);
      for (int i = 0; i < 3; i++) begin
         if (i == 1) idle();
         else if (i == 2) step();
         checks++;
         if (out_valid !== 1'b1 || acc !== exp_acc[i] || count !== 16'(i + 1)) begin
            errors++;
            $display("FAIL b2b_%0d: ov=%0b acc=%h cnt=%0d, want 1 %h %0d",
                     i, out_valid, acc, count, exp_acc[i], i + 1);
         end
      end
      step();
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("FAIL b2b_end: out_valid=%0b, want 0", out_valid);
      end
   endtask

   task automatic test_sign_norm();
      send(1'b1, 32'h3FC00000, 32'h40000000, 1'b1);
      send(1'b1, 32'hC0200000, 32'h3F800000, 1'b0);
      idle();
      step();
      checks++;
      if (acc !== 32'h3F000000 || count !== 16'd2) begin
         errors++;
         $display("FAIL renorm_left: acc=%h cnt=%0d, want 3F000000 2", acc, count);
      end
      send(1'b1, 32'hC0400000, 32'h3F800000, 1'b1);
      send(1'b1, 32'h3F800000, 32'h3F800000, 1'b0);
      idle();
      step();
      checks++;
      if (acc !== 32'hC0000000 || count !== 16'd2) begin
         errors++;
         $display("FAIL neg_plus_pos: acc=%h cnt=%0d, want C0000000 2", acc, count);
      end
      send(1'b1, 32'h3FC00000, 32'h3FC00000, 1'b1);
      idle();
      step();
      checks++;
      if (acc !== 32'h40100000 || count !== 16'd1) begin
         errors++;
         $display("FAIL mul_msb_norm: acc=%h cnt=%0d, want 40100000 1", acc, count);
      end
   endtask

   task automatic test_overflow();
      send(1'b1, 32'h7F000000, 32'h7F000000, 1'b1);
      idle();
      step();
      checks++;
      if (acc !== 32'h7F800000 || ovf !== 1'b1 || count !== 16'd1) begin
         errors++;
         $display("FAIL ovf_set: acc=%h ovf=%0b cnt=%0d, want 7F800000 1 1", acc, ovf, count);
      end
      send(1'b1, 32'h3F800000, 32'h3F800000, 1'b0);
      idle();
      step();
      checks++;
      if (acc !== 32'h7F800000 || ovf !== 1'b1 || count !== 16'd2 || out_valid !== 1'b1) begin
         errors++;
         $display("FAIL ovf_hold: acc=%h ovf=%0b cnt=%0d ov=%0b, want 7F800000 1 2 1",
                  acc, ovf, count, out_valid);
      end
      send(1'b0, 32'h0, 32'h0, 1'b1);
      idle();
      checks++;
      if (acc !== 32'h7F800000 || ovf !== 1'b1) begin
         errors++;
         $display("FAIL clr_early: acc=%h ovf=%0b, want 7F800000 1", acc, ovf);
      end
      step();
      checks++;
      if (acc !== 32'h0 || count !== 16'd0 || ovf !== 1'b0 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL clr_alone: acc=%h cnt=%0d ovf=%0b ov=%0b, want 0 0 0 0",
                  acc, count, ovf, out_valid);
      end
   endtask

   task automatic test_flush();
      send(1'b1, 32'h00400000, 32'h40000000, 1'b1);
      idle();
      step();
      checks++;
      if (acc !== 32'h0 || count !== 16'd1 || out_valid !== 1'b1) begin
         errors++;
         $display("FAIL denorm_flush: acc=%h cnt=%0d ov=%0b, want 0 1 1", acc, count, out_valid);
      end
      send(1'b1, 32'h20000000, 32'h1F000000, 1'b0);
      idle();
      step();
      checks++;
      if (acc !== 32'h0 || count !== 16'd2) begin
         errors++;
         $display("FAIL underflow: acc=%h cnt=%0d, want 0 2", acc, count);
      end
   endtask

   task automatic test_midflight_reset();
      send(1'b1, 32'h3F800000, 32'h3F800000, 1'b1);
      idle();
      step();
      checks++;
      if (acc !== 32'h3F800000 || count !== 16'd1) begin
         errors++;
         $display("FAIL pre_reset: acc=%h cnt=%0d, want 3F800000 1", acc, count);
      end
      send(1'b1, 32'h3FC00000, 32'h40000000, 1'b0);
      @(posedge clk);
      #3;
      rst = 1'b1;
      in_valid = 1'b0;
      #1;
      checks++;
      if ({out_valid, acc, count, ovf} !== 50'h0) begin
         errors++;
         $display("FAIL async_reset: ov=%0b acc=%h cnt=%0d ovf=%0b, want all zero",
                  out_valid, acc, count, ovf);
      end
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         step();
         checks++;
         if (out_valid !== 1'b0 || acc !== 32'h0 || count !== 16'd0) begin
            errors++;
            $display("FAIL discard_%0d: ov=%0b acc=%h cnt=%0d, want 0 0 0",
                     i, out_valid, acc, count);
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_accumulate();
      test_back_to_back();
      test_sign_norm();
      test_overflow();
      test_flush();
      test_midflight_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
